// File: rtl/seg7_scan_mux_if.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_scan_mux_if
//  Brief    : Load strobe / packed BCD input and scan outputs of seg7_scan_mux.
//  Revision : 1.0  initial release
// ============================================================================
interface seg7_scan_mux_if #(
    parameter int NUM_DIGITS = 4
);
    logic                      load;
    logic [4*NUM_DIGITS-1:0]   value;
    logic [NUM_DIGITS-1:0]     dp_in;
    logic [3:0]                digit_code;
    logic [NUM_DIGITS-1:0]     an_n;
    logic                      dp_n;
    logic                      frame_start;

    modport master (
        output load, value, dp_in,
        input  digit_code, an_n, dp_n, frame_start
    );

    modport slave (
        input  load, value, dp_in,
        output digit_code, an_n, dp_n, frame_start
    );
endinterface
`default_nettype wire

// File: rtl/seg7_scan_mux.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_scan_mux
//  Brief    : Multiplexed common-anode 7-segment scan driver with leading-zero
//             blanking, invalid-code blanking and anode dead-time.
//  Revision : 1.0  initial release
// ============================================================================
module seg7_scan_mux #(
    parameter int NUM_DIGITS = 4,
    parameter int PRESCALE   = 50000,
    parameter int DEAD       = 2,
    parameter int BLANK_LEAD = 1
) (
    input  wire logic         clk,
    input  wire logic         rst,
    seg7_scan_mux_if.slave    bus
);
    localparam int C_CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int C_IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int C_VW = 4 * NUM_DIGITS;

    localparam logic [C_CW-1:0] C_CNT_MAX = C_CW'(PRESCALE - 1);
    localparam logic [C_CW-1:0] C_DEAD    = C_CW'(DEAD);
    localparam logic [C_IW-1:0] C_IDX_MAX = C_IW'(NUM_DIGITS - 1);

    logic [C_CW-1:0]       count_q, count_d;
    logic [C_IW-1:0]       idx_q, idx_d;
    logic [C_VW-1:0]       pend_val_q, pend_val_d;
    logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d;
    logic                  pend_valid_q, pend_valid_d;
    logic [C_VW-1:0]       shadow_val_q, shadow_val_d;
    logic [NUM_DIGITS-1:0] shadow_dp_q, shadow_dp_d;
    logic [3:0]            digit_code_q, digit_code_d;
    logic [NUM_DIGITS-1:0] an_n_q, an_n_d;
    logic                  dp_n_q, dp_n_d;
    logic                  frame_start_q, frame_start_d;

    logic                  w_slot_end;
    logic                  w_frame_wrap;
    logic                  w_active;
    logic                  w_blank;
    logic                  w_zero_run;
    logic                  w_cur_lead;
    logic                  w_cur_dp;
    logic [3:0]            w_cur_digit;

    // Scan timing and display-value double buffering
    always_comb begin
        w_slot_end   = (count_q == C_CNT_MAX);
        w_frame_wrap = w_slot_end && (idx_q == C_IDX_MAX);

        count_d = w_slot_end ? '0 : count_q + 1'b1;
        idx_d   = idx_q;
        if (w_slot_end) begin
            idx_d = (idx_q == C_IDX_MAX) ? '0 : idx_q + 1'b1;
        end

        pend_val_d   = pend_val_q;
        pend_dp_d    = pend_dp_q;
        pend_valid_d = pend_valid_q;
        shadow_val_d = shadow_val_q;
        shadow_dp_d  = shadow_dp_q;

        if (bus.load) begin
            pend_val_d   = bus.value;
            pend_dp_d    = bus.dp_in;
            pend_valid_d = 1'b1;
        end

        // A load on the wrap cycle bypasses the pending stage entirely
        if (w_frame_wrap) begin
            pend_valid_d = 1'b0;
            if (bus.load) begin
                shadow_val_d = bus.value;
                shadow_dp_d  = bus.dp_in;
            end else if (pend_valid_q) begin
                shadow_val_d = pend_val_q;
                shadow_dp_d  = pend_dp_q;
            end
        end
    end

    // Digit selection; the zero run is accumulated from the most significant digit down
    always_comb begin
        w_zero_run  = 1'b1;
        w_cur_lead  = 1'b0;
        w_cur_dp    = 1'b0;
        w_cur_digit = 4'h0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            w_zero_run = w_zero_run && (shadow_val_q[4*k +: 4] == 4'h0);
            if (C_IW'(k) == idx_q) begin
                w_cur_digit = shadow_val_q[4*k +: 4];
                w_cur_dp    = shadow_dp_q[k];
                w_cur_lead  = w_zero_run && (k != 0);
            end
        end

        w_active = (count_q >= C_DEAD);
        w_blank  = (w_cur_digit > 4'd9) || ((BLANK_LEAD != 0) && w_cur_lead);

        digit_code_d = w_blank ? 4'hF : w_cur_digit;
        an_n_d       = '1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            an_n_d[k] = !(w_active && !w_blank && (C_IW'(k) == idx_q));
        end
        dp_n_d        = !(w_cur_dp && w_active);
        frame_start_d = (count_q == '0) && (idx_q == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q       <= '0;
            idx_q         <= '0;
            pend_val_q    <= '0;
            pend_dp_q     <= '0;
            pend_valid_q  <= 1'b0;
            shadow_val_q  <= '0;
            shadow_dp_q   <= '0;
            digit_code_q  <= 4'h0;
            an_n_q        <= '1;
            dp_n_q        <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            count_q       <= count_d;
            idx_q         <= idx_d;
            pend_val_q    <= pend_val_d;
            pend_dp_q     <= pend_dp_d;
            pend_valid_q  <= pend_valid_d;
            shadow_val_q  <= shadow_val_d;
            shadow_dp_q   <= shadow_dp_d;
            digit_code_q  <= digit_code_d;
            an_n_q        <= an_n_d;
            dp_n_q        <= dp_n_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign bus.digit_code  = digit_code_q;
    assign bus.an_n        = an_n_q;
    assign bus.dp_n        = dp_n_q;
    assign bus.frame_start = frame_start_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_mux.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seg7_scan_mux
//  Brief    : Directed, table-driven bench for seg7_scan_mux (4 digits, 4-cycle
//             slots, 1-cycle dead time, leading-zero blanking on).
//  Revision : 1.0  initial release
// ============================================================================
module tb_seg7_scan_mux;

    typedef struct {
        logic [15:0] value;
        logic [3:0]  dp;
        logic [15:0] codes;   // expected digit_code per slot, nibble s = slot s
        logic [3:0]  lit;     // slots whose anode is driven
    } vec_t;

    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;
    vec_t tbl [6];

    seg7_scan_mux_if #(.NUM_DIGITS(4)) bus ();

    seg7_scan_mux #(
        .NUM_DIGITS (4),
        .PRESCALE   (4),
        .DEAD       (1),
        .BLANK_LEAD (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic check_reset_outputs(input string name);
        check(name, {28'd0, bus.frame_start, bus.an_n, bus.dp_n, bus.digit_code},
              {28'd0, 1'b0, 4'hF, 1'b1, 4'h0});
    endtask

    // Called at the cycle frame_start is expected; leaves the bench at the next frame start
    task automatic check_frame(input logic [15:0] codes, input logic [3:0] lit,
                               input logic [3:0] dpm, input string name);
        for (int i = 0; i < 16; i++) begin
            int         s;
            int         c;
            logic [3:0] exp_an;
            logic       exp_dp;
            s      = i / 4;
            c      = i % 4;
            exp_an = (c >= 1 && lit[s]) ? ~(4'b0001 << s) : 4'hF;
            exp_dp = !(dpm[s] && c >= 1);
            check($sformatf("%s[s%0d c%0d] fs/an/code/dp", name, s, c),
                  {22'd0, bus.frame_start, bus.an_n, bus.digit_code, bus.dp_n},
                  {22'd0, (i == 0), exp_an, codes[4*s +: 4], exp_dp});
            tick();
        end
    endtask

    task automatic wait_frame(input string name);
        int n;
        n = 0;
        while (bus.frame_start !== 1'b1 && n < 64) begin
            tick();
            n++;
        end
        check({name, " frame_start seen"}, {31'd0, bus.frame_start}, 32'd1);
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d);
        bus.value = v;
        bus.dp_in = d;
        bus.load  = 1'b1;
        tick();
        bus.load  = 1'b0;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;

        tbl[0] = '{value: 16'h1234, dp: 4'b0100, codes: 16'h1234, lit: 4'b1111};
        tbl[1] = '{value: 16'h0042, dp: 4'b0000, codes: 16'hFF42, lit: 4'b0011};
        tbl[2] = '{value: 16'h0000, dp: 4'b0000, codes: 16'hFFF0, lit: 4'b0001};
        tbl[3] = '{value: 16'h12A4, dp: 4'b0010, codes: 16'h12F4, lit: 4'b1101};
        tbl[4] = '{value: 16'h0900, dp: 4'b1000, codes: 16'hF900, lit: 4'b0111};
        tbl[5] = '{value: 16'hF000, dp: 4'b0000, codes: 16'hF000, lit: 4'b0111};

        rst       = 1'b1;
        bus.load  = 1'b0;
        bus.value = 16'h0;
        bus.dp_in = 4'h0;

        for (int i = 0; i < 3; i++) begin
            tick();
            check_reset_outputs($sformatf("reset_hold%0d", i));
        end
        rst = 1'b0;
        tick();
        check_frame(16'hFFF0, 4'b0001, 4'b0000, "after_reset");

        // Each vector must show up in the frame immediately following its load
        for (int t = 0; t < 6; t++) begin
            do_load(tbl[t].value, tbl[t].dp);
            tick();
            wait_frame($sformatf("vec%0d", t));
            check_frame(tbl[t].codes, tbl[t].lit, tbl[t].dp, $sformatf("vec%0d", t));
        end

        // Two loads inside one frame: only the last is displayed
        tick();
        tick();
        do_load(16'h5555, 4'h0);
        tick();
        tick();
        do_load(16'h6666, 4'h0);
        begin
            int n;
            n = 0;
            while (bus.frame_start !== 1'b1 && n < 64) begin
                check("no_early_5", {31'd0, bus.digit_code == 4'h5}, 32'd0);
                tick();
                n++;
            end
        end
        check("last_load frame_start seen", {31'd0, bus.frame_start}, 32'd1);
        check_frame(16'h6666, 4'b1111, 4'b0000, "last_load_wins");

        // Load sampled exactly on the wrap edge is shown in the frame that follows
        for (int i = 0; i < 14; i++) tick();
        do_load(16'h0789, 4'b0001);
        tick();
        check_frame(16'hF789, 4'b0111, 4'b0001, "wrap_load");

        // Reset mid-slot 2 clears the display and restarts the scan
        for (int i = 0; i < 9; i++) tick();
        rst = 1'b1;
        tick();
        check_reset_outputs("mid_reset");
        rst = 1'b0;
        tick();
        check_frame(16'hFFF0, 4'b0001, 4'b0000, "post_mid_reset");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
